// File: rtl/depth_frame_ctrl_pkg.sv
// Shared types for the depth frame controller: command opcodes, depth compare
// functions, fragment/colour formats and the depth configuration record.
package depth_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    SET_STATE = 2'd0,
    CLEAR     = 2'd1,
    FLUSH     = 2'd2,
    NOP       = 2'd3
  } depth_cmd_op_t;

  typedef enum logic [2:0] {
    GR_CMP_NEVER    = 3'd0,
    GR_CMP_LESS     = 3'd1,
    GR_CMP_EQUAL    = 3'd2,
    GR_CMP_LEQUAL   = 3'd3,
    GR_CMP_GREATER  = 3'd4,
    GR_CMP_NOTEQUAL = 3'd5,
    GR_CMP_GEQUAL   = 3'd6,
    GR_CMP_ALWAYS   = 3'd7
  } depth_func_t;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] z;
  } fragment_t;

  typedef struct packed {
    logic        test_en;
    logic        write_en;
    depth_func_t func;
  } depth_cfg_t;

  localparam int            DEPTH_PIPE_DEPTH = 3;
  localparam logic [15:0]   CLEAR_VALUE_RST  = 16'hFFFF;
  localparam depth_cfg_t    DEPTH_CFG_RST    = '{test_en: 1'b0, write_en: 1'b0, func: GR_CMP_LESS};

  // SET_STATE operand layout: [0] test_en, [1] write_en, [4:2] func.
  function automatic depth_cfg_t cfg_from_cmd(input logic [4:0] data);
    depth_cfg_t cfg;
    cfg.test_en  = data[0];
    cfg.write_en = data[1];
    cfg.func     = depth_func_t'(data[4:2]);
    return cfg;
  endfunction

endpackage

// File: rtl/depth_frame_ctrl_if.sv
// Bundle of command, fragment, depth_buffer config and status signals around
// depth_frame_ctrl; master is the controller side, slave the surroundings.
interface depth_frame_ctrl_if #(parameter int FRAME_CNT_W = 16);
  import depth_frame_ctrl_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  depth_cmd_op_t          cmd_op;
  logic [31:0]            cmd_data;
  fragment_t              up_frag;
  rgb565_t                up_color;
  logic                   up_valid;
  logic                   up_ready;
  fragment_t              db_frag;
  rgb565_t                db_color;
  logic                   db_valid;
  logic                   db_ready;
  logic                   db_out_valid;
  logic                   db_out_ready;
  logic                   depth_test_enable;
  logic                   depth_write_enable;
  depth_func_t            depth_func;
  logic                   depth_clear;
  logic [15:0]            depth_clear_value;
  logic                   depth_clearing;
  logic                   busy;
  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, up_frag, up_color, up_valid, db_ready,
           db_out_valid, db_out_ready, depth_clearing,
    output cmd_ready, up_ready, db_frag, db_color, db_valid, depth_test_enable,
           depth_write_enable, depth_func, depth_clear, depth_clear_value,
           busy, frame_done, frame_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, up_frag, up_color, up_valid, db_ready,
           db_out_valid, db_out_ready, depth_clearing,
    input  cmd_ready, up_ready, db_frag, db_color, db_valid, depth_test_enable,
           depth_write_enable, depth_func, depth_clear, depth_clear_value,
           busy, frame_done, frame_count
  );

endinterface

// File: rtl/depth_frame_ctrl_pipe_drain_mon.sv
// Counts consecutive non-stalled cycles at the depth_buffer output; drained is
// raised on the cycle that completes PIPE_DEPTH clean cycles.
module pipe_drain_mon
  import depth_frame_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = DEPTH_PIPE_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_active,
  input  logic i_stall,
  output logic o_drained
);

  localparam int               CNT_W   = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPE_DEPTH);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (i_active && i_stall)) begin
      r_cnt <= '0;
    end else if (i_active && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Combinational so the FSM leaves DRAIN on the PIPE_DEPTH-th clean cycle.
  assign o_drained = i_active && !i_stall && (r_cnt >= (CNT_MAX - 1'b1));

endmodule

// File: rtl/depth_frame_ctrl.sv
// Depth command sequencer: owns depth config, gates fragments into depth_buffer,
// and runs CLEAR/FLUSH only after the depth pipeline has drained.
//
// state          | meaning
// ST_RUN         | gate open, commands accepted
// ST_DRAIN       | gate closed, waiting for PIPE_DEPTH clean output cycles
// ST_CLR_ISSUE   | one-cycle depth_clear pulse
// ST_CLR_WAIT_HI | waiting for depth_clearing to rise
// ST_CLR_WAIT_LO | waiting for depth_clearing to fall
// ST_DONE        | one-cycle frame_done pulse, frame_count advances
module depth_frame_ctrl
  import depth_frame_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH  = DEPTH_PIPE_DEPTH,
  parameter int FRAME_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  depth_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_RUN, ST_DRAIN, ST_CLR_ISSUE, ST_CLR_WAIT_HI, ST_CLR_WAIT_LO, ST_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  depth_cfg_t             r_cfg;
  logic                   r_op_clear;
  logic [15:0]            r_clear_pend;
  logic [15:0]            r_clear_value;
  logic                   r_busy;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic                   w_cmd_ready;
  logic                   w_up_ready;
  logic                   w_db_valid;
  logic                   w_depth_clear;
  logic                   w_frame_done;
  logic                   w_accept;
  logic                   w_drain_start;
  logic                   w_drained;
  logic                   w_unused_cmd_bits;

  assign w_accept          = bus.cmd_valid && w_cmd_ready;
  assign w_drain_start     = (r_state == ST_RUN) && (w_state_nxt == ST_DRAIN);
  assign w_unused_cmd_bits = ^bus.cmd_data[31:16];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:
        if (w_accept && ((bus.cmd_op == CLEAR) || (bus.cmd_op == FLUSH)))
          w_state_nxt = ST_DRAIN;
      ST_DRAIN:
        if (w_drained) w_state_nxt = r_op_clear ? ST_CLR_ISSUE : ST_DONE;
      ST_CLR_ISSUE:   w_state_nxt = ST_CLR_WAIT_HI;
      ST_CLR_WAIT_HI: if (bus.depth_clearing)  w_state_nxt = ST_CLR_WAIT_LO;
      ST_CLR_WAIT_LO: if (!bus.depth_clearing) w_state_nxt = ST_RUN;
      ST_DONE:        w_state_nxt = ST_RUN;
      default:        w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_cmd_ready   = (r_state == ST_RUN);
    w_up_ready    = (r_state == ST_RUN) && bus.db_ready;
    w_db_valid    = (r_state == ST_RUN) && bus.up_valid;
    w_depth_clear = (r_state == ST_CLR_ISSUE);
    w_frame_done  = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg         <= DEPTH_CFG_RST;
      r_op_clear    <= 1'b0;
      r_clear_pend  <= CLEAR_VALUE_RST;
      r_clear_value <= CLEAR_VALUE_RST;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_accept && (bus.cmd_op == SET_STATE)) r_cfg <= cfg_from_cmd(bus.cmd_data[4:0]);
      if (w_accept && (bus.cmd_op == CLEAR))     r_clear_pend <= bus.cmd_data[15:0];
      if (w_drain_start)                         r_op_clear <= (bus.cmd_op == CLEAR);
      // Loaded on entry so the value is already stable during the clear pulse.
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_CLR_ISSUE)) r_clear_value <= r_clear_pend;
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE))      r_frame_count <= r_frame_count + 1'b1;
      r_busy <= (w_state_nxt != ST_RUN);
    end
  end

  pipe_drain_mon #(.PIPE_DEPTH(PIPE_DEPTH)) u_drain_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_drain_start),
    .i_active  (r_state == ST_DRAIN),
    .i_stall   (bus.db_out_valid && !bus.db_out_ready),
    .o_drained (w_drained)
  );

  assign bus.cmd_ready          = w_cmd_ready;
  assign bus.up_ready           = w_up_ready;
  assign bus.db_valid           = w_db_valid;
  assign bus.db_frag            = bus.up_frag;
  assign bus.db_color           = bus.up_color;
  assign bus.depth_test_enable  = r_cfg.test_en;
  assign bus.depth_write_enable = r_cfg.write_en;
  assign bus.depth_func         = r_cfg.func;
  assign bus.depth_clear        = w_depth_clear;
  assign bus.depth_clear_value  = r_clear_value;
  assign bus.busy               = r_busy;
  assign bus.frame_done         = w_frame_done;
  assign bus.frame_count        = r_frame_count;

endmodule
